// File: rtl/fp_sub_seq.sv
// Multi-cycle floating-point subtractor (A - B) with valid/ready handshakes.
// Alignment and normalisation shift one bit per cycle.
module fp_sub_seq #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]     A_FP,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]     B_FP,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       sign,
    output logic [EXPONENT_WIDTH-1:0]                  exponent,
    output logic [MANTISSA_WIDTH-1:0]                  mantissa,
    output logic                                       busy
);
    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
    localparam int W  = 1 + EW + MW;

    localparam logic [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic [EW-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0] MAX_D    = EW'(MW + 1);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, COMPUTE, NORM, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [MW:0]   x_man_q, x_man_d, y_man_q, y_man_d;
    logic [EW-1:0] exp_q, exp_d, d_q, d_d;
    logic          res_sign_q, res_sign_d, eff_sub_q, eff_sub_d;
    logic [MW+1:0] sum_q, sum_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] exponent_q, exponent_d;
    logic [MW-1:0] mantissa_q, mantissa_d;

    logic [EW-1:0] ea, eb, ex, ey, d_full;
    logic [MW:0]   ma, mb, mx, my;
    logic          a_big, sx;
    logic [MW+1:0] sum_calc;

    // Operand unpack and magnitude ordering; a zero exponent means an exact zero.
    always_comb begin
        ea       = a_q[MW +: EW];
        eb       = b_q[MW +: EW];
        ma       = (ea == '0) ? '0 : {1'b1, a_q[MW-1:0]};
        mb       = (eb == '0) ? '0 : {1'b1, b_q[MW-1:0]};
        a_big    = {ea, ma} >= {eb, mb};
        ex       = a_big ? ea : eb;
        ey       = a_big ? eb : ea;
        mx       = a_big ? ma : mb;
        my       = a_big ? mb : ma;
        sx       = a_big ? a_q[W-1] : b_q[W-1];
        d_full   = ex - ey;
        sum_calc = eff_sub_q ? ({1'b0, x_man_q} - {1'b0, y_man_q})
                             : ({1'b0, x_man_q} + {1'b0, y_man_q});
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        x_man_d    = x_man_q;
        y_man_d    = y_man_q;
        exp_d      = exp_q;
        d_d        = d_q;
        res_sign_d = res_sign_q;
        eff_sub_d  = eff_sub_q;
        sum_d      = sum_q;
        sign_d     = sign_q;
        exponent_d = exponent_q;
        mantissa_d = mantissa_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A_FP;
                    b_d     = {~B_FP[W-1], B_FP[W-2:0]};
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                x_man_d    = mx;
                exp_d      = ex;
                res_sign_d = sx;
                eff_sub_d  = a_q[W-1] ^ b_q[W-1];
                if (d_full > MAX_D) begin
                    y_man_d = '0;
                    d_d     = '0;
                    state_d = COMPUTE;
                end else begin
                    y_man_d = my;
                    d_d     = d_full;
                    state_d = (d_full == '0) ? COMPUTE : ALIGN;
                end
            end
            ALIGN: begin
                y_man_d = y_man_q >> 1;
                d_d     = d_q - EXP_ONE;
                if (d_q == EXP_ONE) state_d = COMPUTE;
            end
            COMPUTE: begin
                sum_d = sum_calc;
                if (sum_calc == '0) begin
                    sign_d     = 1'b0;
                    exponent_d = '0;
                    mantissa_d = '0;
                    state_d    = DONE;
                end else if (sum_calc[MW+1] || !sum_calc[MW]) begin
                    state_d = NORM;
                end else begin
                    sign_d     = res_sign_q;
                    exponent_d = exp_q;
                    mantissa_d = sum_calc[MW-1:0];
                    state_d    = DONE;
                end
            end
            NORM: begin
                // Carry needs a single right shift; otherwise shift left until the hidden bit lands.
                if (sum_q[MW+1]) begin
                    sign_d  = res_sign_q;
                    state_d = DONE;
                    if (exp_q >= EXP_ONES - EXP_ONE) begin
                        exponent_d = EXP_ONES;
                        mantissa_d = '0;
                    end else begin
                        exponent_d = exp_q + EXP_ONE;
                        mantissa_d = sum_q[MW:1];
                    end
                end else if (exp_q <= EXP_ONE) begin
                    sign_d     = 1'b0;
                    exponent_d = '0;
                    mantissa_d = '0;
                    state_d    = DONE;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - EXP_ONE;
                    if (sum_q[MW-1]) begin
                        sign_d     = res_sign_q;
                        exponent_d = exp_q - EXP_ONE;
                        mantissa_d = {sum_q[MW-2:0], 1'b0};
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            x_man_q    <= '0;
            y_man_q    <= '0;
            exp_q      <= '0;
            d_q        <= '0;
            res_sign_q <= 1'b0;
            eff_sub_q  <= 1'b0;
            sum_q      <= '0;
            sign_q     <= 1'b0;
            exponent_q <= '0;
            mantissa_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            x_man_q    <= x_man_d;
            y_man_q    <= y_man_d;
            exp_q      <= exp_d;
            d_q        <= d_d;
            res_sign_q <= res_sign_d;
            eff_sub_q  <= eff_sub_d;
            sum_q      <= sum_d;
            sign_q     <= sign_d;
            exponent_q <= exponent_d;
            mantissa_q <= mantissa_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign sign      = sign_q;
    assign exponent  = exponent_q;
    assign mantissa  = mantissa_q;
endmodule
